shift_arbiter: RTL

//  Shares one logical-right barrel shifter (shifter_rlN datapath) between R

---
 rtl/shift_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one logical-right shifter between R requesters.
// The result is registered with the requester id and held until the consumer accepts it.
module shift_arbiter #(
    parameter int unsigned N = 11,
    parameter int unsigned S = 4,
    parameter int unsigned R = 2,
    parameter int unsigned I = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*S-1:0] req_s,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_y,
    output logic [I-1:0]   rsp_id
);

    typedef enum logic [0:0] {StIdle, StFull} state_e;

    state_e         r_state;
    state_e         w_state_nxt;
    logic [I-1:0]   r_rr_ptr;
    logic [N-1:0]   r_rsp_y;
    logic [I-1:0]   r_rsp_id;

    logic [I-1:0]   w_grant;
    logic           w_any;
    logic           w_take;
    logic [N-1:0]   w_a;
    logic [S-1:0]   w_s;
    logic [N-1:0]   w_y;

    // First valid port searching upward from rr_ptr+1, wrapping mod R.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx     = 0;
        found   = 1'b0;
        w_grant = '0;
        for (int unsigned k = 1; k <= R; k++) begin
            idx = (32'(r_rr_ptr) + k) % R;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                w_grant = I'(idx);
            end
        end
    end

    assign w_any  = |req_valid;
    // Reset gates the grant so no handshake completes while rst is high.
    assign w_take = !rst && w_any && ((r_state == StIdle) || rsp_ready);

    assign req_ready = w_take ? (R'(1) << w_grant) : '0;

    assign w_a = req_a[32'(w_grant) * N +: N];
    assign w_s = req_s[32'(w_grant) * S +: S];
    // Explicit saturation: any amount >= N yields zero.
    assign w_y = (32'(w_s) >= N) ? '0 : (w_a >> w_s);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_take) w_state_nxt = StFull;
            StFull: if (rsp_ready && !w_any) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_rsp_y  <= '0;
            r_rsp_id <= '0;
            r_rr_ptr <= I'(R - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_rsp_y  <= w_y;
                r_rsp_id <= w_grant;
                r_rr_ptr <= w_grant;
            end
        end
    end

    assign rsp_valid = (r_state == StFull);
    assign rsp_y     = r_rsp_y;
    assign rsp_id    = r_rsp_id;

endmodule
